// File: rtl/alu_arb_pkg.sv
// Shared types and helpers for the two-requester ALU arbiter.
// Holds the FSM state encoding, the multiply command codes, the multiply
// detection helper and the bit positions inside the captured flag vector.
package alu_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam logic [3:0] CMD_MUL_INC = 4'd9;
  localparam logic [3:0] CMD_MUL_SHL = 4'd10;

  // Flag vector layout: {COUT, OFLOW, G, E, L, ERR}
  localparam int FLAG_W     = 6;
  localparam int FLAG_ERR   = 0;
  localparam int FLAG_L     = 1;
  localparam int FLAG_E     = 2;
  localparam int FLAG_G     = 3;
  localparam int FLAG_OFLOW = 4;
  localparam int FLAG_COUT  = 5;

  // Multiplies only exist in arithmetic mode; the same codes in logic mode are ordinary ops
  function automatic logic is_mul(input logic mode, input logic [3:0] cmd);
    return mode && ((cmd == CMD_MUL_INC) || (cmd == CMD_MUL_SHL));
  endfunction

endpackage

// File: rtl/alu_req_arbiter_rr_arb2.sv
// Two-way round-robin grant logic.
// 'last' is the requester that won most recently; on a tie the other one
// wins, and a lone requester always wins. Output is onehot0.
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       last,
  output logic [1:0] gnt
);

  // Tie goes to whoever did not win last; otherwise the grant simply follows the request
  always_comb begin
    gnt = 2'b00;
    if (req == 2'b11) begin
      gnt = last ? 2'b01 : 2'b10;
    end else begin
      gnt = req;
    end
  end

endmodule

// File: rtl/alu_req_arbiter.sv
// Shares one ALU between two requesters.
// Requests are accepted over valid/ready with round-robin arbitration, the
// chosen operation is held on the ALU inputs for the command-dependent
// latency, and the ALU result plus flags are returned on a single response
// port tagged with the owning requester.
// Optional macro ALU_ARB_STATS_EN adds saturating grant and busy counters.
module alu_req_arbiter
  import alu_arb_pkg::*;
#(
  parameter int N       = 8,
  parameter int ALU_LAT = 1,
  parameter int MUL_LAT = 2
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [1:0]       REQ_VALID,
  output logic [1:0]       REQ_READY,
  input  logic [2*N-1:0]   REQ_OPA,
  input  logic [2*N-1:0]   REQ_OPB,
  input  logic [7:0]       REQ_CMD,
  input  logic [1:0]       REQ_MODE,
  input  logic [1:0]       REQ_CIN,
  input  logic [3:0]       REQ_INP_VALID,
  output logic [N-1:0]     ALU_OPA,
  output logic [N-1:0]     ALU_OPB,
  output logic [3:0]       ALU_CMD,
  output logic             ALU_MODE,
  output logic             ALU_CIN,
  output logic             ALU_CE,
  output logic [1:0]       ALU_INP_VALID,
  input  logic [2*N-1:0]   ALU_RES,
  input  logic             ALU_COUT,
  input  logic             ALU_OFLOW,
  input  logic             ALU_G,
  input  logic             ALU_E,
  input  logic             ALU_L,
  input  logic             ALU_ERR,
  output logic             RSP_VALID,
  input  logic             RSP_READY,
  output logic             RSP_ID,
  output logic [2*N-1:0]   RSP_RES,
  output logic [FLAG_W-1:0] RSP_FLAGS
`ifdef ALU_ARB_STATS_EN
  ,
  output logic [15:0]      GNT_CNT0,
  output logic [15:0]      GNT_CNT1,
  output logic [15:0]      BUSY_CYC
`endif
);

  state_t      r_state;
  logic        r_rrPtr;
  logic        r_owner;
  logic [7:0]  r_cnt;

  logic [1:0]        w_gnt;
  logic              w_fire;
  logic              w_winner;
  logic [N-1:0]      w_selOpa;
  logic [N-1:0]      w_selOpb;
  logic [3:0]        w_selCmd;
  logic              w_selMode;
  logic              w_selCin;
  logic [1:0]        w_selInpValid;
  logic [FLAG_W-1:0] w_flags;

  rr_arb2 u_rrArb (
    .req  (REQ_VALID),
    .last (r_rrPtr),
    .gnt  (w_gnt)
  );

  // Grants are only offered while idle and out of reset, so nothing is accepted mid-operation
  assign REQ_READY = ((r_state == IDLE) && !RST) ? w_gnt : 2'b00;
  assign w_fire    = |(REQ_VALID & REQ_READY);
  assign w_winner  = REQ_READY[1];

  // Pick the winning requester's fields out of the packed request buses
  always_comb begin
    w_selOpa      = w_winner ? REQ_OPA[2*N-1:N] : REQ_OPA[N-1:0];
    w_selOpb      = w_winner ? REQ_OPB[2*N-1:N] : REQ_OPB[N-1:0];
    w_selCmd      = w_winner ? REQ_CMD[7:4]     : REQ_CMD[3:0];
    w_selMode     = w_winner ? REQ_MODE[1]      : REQ_MODE[0];
    w_selCin      = w_winner ? REQ_CIN[1]       : REQ_CIN[0];
    w_selInpValid = w_winner ? REQ_INP_VALID[3:2] : REQ_INP_VALID[1:0];
  end

  // Pack the ALU status lines into the response flag layout
  always_comb begin
    w_flags             = '0;
    w_flags[FLAG_COUT]  = ALU_COUT;
    w_flags[FLAG_OFLOW] = ALU_OFLOW;
    w_flags[FLAG_G]     = ALU_G;
    w_flags[FLAG_E]     = ALU_E;
    w_flags[FLAG_L]     = ALU_L;
    w_flags[FLAG_ERR]   = ALU_ERR;
  end

  // Main control: accept, hold the ALU inputs for the op latency, capture, then wait for the consumer
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state       <= IDLE;
      r_rrPtr       <= 1'b1;
      r_owner       <= 1'b0;
      r_cnt         <= 8'd0;
      ALU_OPA       <= '0;
      ALU_OPB       <= '0;
      ALU_CMD       <= 4'd0;
      ALU_MODE      <= 1'b0;
      ALU_CIN       <= 1'b0;
      ALU_CE        <= 1'b0;
      ALU_INP_VALID <= 2'b00;
      RSP_VALID     <= 1'b0;
      RSP_ID        <= 1'b0;
      RSP_RES       <= '0;
      RSP_FLAGS     <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_fire) begin
            ALU_OPA       <= w_selOpa;
            ALU_OPB       <= w_selOpb;
            ALU_CMD       <= w_selCmd;
            ALU_MODE      <= w_selMode;
            ALU_CIN       <= w_selCin;
            ALU_INP_VALID <= w_selInpValid;
            ALU_CE        <= 1'b1;
            r_cnt         <= is_mul(w_selMode, w_selCmd) ? 8'(MUL_LAT) : 8'(ALU_LAT);
            r_owner       <= w_winner;
            r_rrPtr       <= w_winner;
            r_state       <= WAIT;
          end
        end
        WAIT: begin
          r_cnt <= r_cnt - 8'd1;
          if (r_cnt == 8'd1) begin
            RSP_RES   <= ALU_RES;
            RSP_FLAGS <= w_flags;
            RSP_ID    <= r_owner;
            RSP_VALID <= 1'b1;
            ALU_CE    <= 1'b0;
            r_state   <= RESP;
          end
        end
        RESP: begin
          if (RSP_READY) begin
            RSP_VALID <= 1'b0;
            r_state   <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

`ifdef ALU_ARB_STATS_EN
  // Saturating usage statistics: grants per requester and cycles spent away from IDLE
  always_ff @(posedge CLK) begin
    if (RST) begin
      GNT_CNT0 <= 16'd0;
      GNT_CNT1 <= 16'd0;
      BUSY_CYC <= 16'd0;
    end else begin
      if (w_fire && !w_winner && (GNT_CNT0 != 16'hFFFF)) GNT_CNT0 <= GNT_CNT0 + 16'd1;
      if (w_fire && w_winner && (GNT_CNT1 != 16'hFFFF))  GNT_CNT1 <= GNT_CNT1 + 16'd1;
      if ((r_state != IDLE) && (BUSY_CYC != 16'hFFFF))   BUSY_CYC <= BUSY_CYC + 16'd1;
    end
  end
`endif

endmodule
